// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg: state encoding shared by the bit-serial adder files
package bit_serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bit_serial_adder_fulladder.sv
// fulladder: one-bit full-adder cell
//   a, b, c_in : addend bits and carry in
//   s, c_out   : sum bit and carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial add of two WIDTH-bit operands over WIDTH cycles
//   clk, rst_n (async, active-low); start accepted only in IDLE, capturing a, b, c_in
//   busy high during RUN; done pulses one cycle when sum/c_out are valid
//   sum/c_out hold from done until the next accepted start
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CNT_W-1:0] cnt;
  logic             carry, s, co, last;
  fulladder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .c_in (carry),
    .s    (s),
    .c_out(co)
  );
  assign last  = cnt == CNT_W'(WIDTH - 1);
  assign busy  = state == RUN;
  assign done  = state == DONE;
  assign sum   = res;
  assign c_out = carry;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  // the result register fills from the MSB, so after WIDTH shifts bit 0 is the first sum bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      sa    <= a;
      sb    <= b;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= {s, res[WIDTH-1:1]};
      carry <= co;
      cnt   <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: random and directed checks of bit_serial_adder against arithmetic sums
module tb_bit_serial_adder;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start8 = 1'b0, ci8 = 1'b0, busy8, done8, co8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start3 = 1'b0, ci3 = 1'b0, busy3, done3, co3;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
  );
  bit_serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c_in(ci3),
    .busy(busy3), .done(done3), .sum(sum3), .c_out(co3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one WIDTH=8 add started in cycle 0; disturb re-pulses start and changes operands mid-RUN
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic ci, input bit disturb);
    logic [8:0] e;
    e = 9'(x) + 9'(y) + 9'(ci);
    a8 = x;
    b8 = y;
    ci8 = ci;
    start8 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 1) start8 = 1'b0;
      if (disturb && c == 4) begin
        start8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        ci8 = 1'b1;
      end
      if (disturb && c == 5) start8 = 1'b0;
      if (disturb && c == 6) a8 = 8'($urandom);
      chk("busy8", 32'(busy8), 32'(c <= 8));
      chk("done8", 32'(done8), 32'(c == 9));
      if (c >= 9) chk("sum8", 32'({co8, sum8}), 32'(e));
    end
  endtask
  task automatic op3(input logic [2:0] x, input logic [2:0] y, input logic ci);
    int e;
    e = int'(x) + int'(y) + int'(ci);
    a3 = x;
    b3 = y;
    ci3 = ci;
    start3 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 1) start3 = 1'b0;
      chk("busy3", 32'(busy3), 32'(c <= 3));
      chk("done3", 32'(done3), 32'(c == 4));
      if (c >= 4) chk("sum3", 32'({co3, sum3}), 32'(e));
    end
  endtask
  initial begin
    logic [8:0] e;
    repeat (2) tick;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'({co8, sum8}), 32'd0);
    chk("rst_sum3", 32'({busy3, done3, co3, sum3}), 32'd0);
    rst_n = 1'b1;
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 1'b1);
    a8 = 8'h80;
    b8 = 8'h80;
    ci8 = 1'b0;
    start8 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      start8 = 1'b0;
    end
    chk("mid_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'({busy8, done8, co8, sum8}), 32'd0);
    for (int c = 0; c < 12; c++) begin
      tick;
      chk("arst_hold", 32'({busy8, done8, co8, sum8}), 32'd0);
      if (c == 2) rst_n = 1'b1;
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    op8(8'h80, 8'h80, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      ci8 = 1'($urandom);
      start8 = 1'b1;
      if (c % 10 == 0) e = 9'(a8) + 9'(b8) + 9'(ci8);
      tick;
      chk("cont_done", 32'(done8), 32'((c + 1) % 10 == 9));
      if ((c + 1) % 10 == 9) chk("cont_sum", 32'({co8, sum8}), 32'(e));
      if ((c + 1) % 10 == 0) chk("cont_hold", 32'({co8, sum8}), 32'(e));
    end
    start8 = 1'b0;
    tick;
    for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 1000; i++) op3(3'($urandom), 3'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
